// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, drain FSM states and the
// store width encodings used by the memory stage.
package store_buffer_pkg;

  localparam int STORE_BUFFER_SIZE = 4;

  typedef logic [31:0] bus32_t;
  typedef logic [$clog2(STORE_BUFFER_SIZE)-1:0] store_buffer_idx_t;

  // One buffered store, already formatted for the data memory bus.
  typedef struct packed {
    bus32_t     addr;
    bus32_t     data;
    logic [3:0] be;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_REQ
  } sb_state_t;

  localparam logic [2:0] FUNC3_SB = 3'b000;
  localparam logic [2:0] FUNC3_SH = 3'b001;
  localparam logic [2:0] FUNC3_SW = 3'b010;

endpackage

// File: rtl/store_align.sv
// Moves store data onto the byte lanes selected by the low address bits and
// produces the matching byte enables. Purely combinational so the load path
// can reuse it.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0] byte_off,
  input  bus32_t     data,
  input  logic [2:0] func3,
  output bus32_t     lane_data,
  output logic [3:0] lane_be
);

  // Replicate the narrow value across the word and select lanes by offset.
  always_comb begin
    lane_data = data;
    lane_be   = 4'b0000;
    case (func3)
      FUNC3_SB: begin
        lane_data = {4{data[7:0]}};
        lane_be   = 4'b0001 << byte_off;
      end
      FUNC3_SH: begin
        lane_data = {2{data[15:0]}};
        lane_be   = 4'b0011 << {byte_off[1], 1'b0};
      end
      FUNC3_SW: begin
        lane_data = data;
        lane_be   = 4'b1111;
      end
      default: begin
        lane_data = data;
        lane_be   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and data memory.
// Entries live between three circular pointers: [head, cmt) are committed
// and waiting to drain, [cmt, tail) are speculative and discarded on flush.
// Optional feature macro: STORE_FWD_EN adds store-to-load forwarding of
// full-word stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SIZE = STORE_BUFFER_SIZE
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              alloc_valid_i,
  input  bus32_t            alloc_addr_i,
  input  bus32_t            alloc_data_i,
  input  logic [2:0]        alloc_func3_i,
  output store_buffer_idx_t alloc_idx_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic              commit_valid_i,
  input  store_buffer_idx_t commit_idx_i,
  input  logic              flush_i,
`ifdef STORE_FWD_EN
  input  bus32_t            fwd_addr_i,
  output logic              fwd_hit_o,
  output bus32_t            fwd_data_o,
`endif
  output logic              dmem_req_o,
  output bus32_t            dmem_addr_o,
  output bus32_t            dmem_data_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_ack_i
);

  localparam int IW = $clog2(SIZE);
  localparam int PW = IW + 1;

  sb_entry_t       entries [SIZE];
  logic [PW-1:0]   head_ptr, cmt_ptr, tail_ptr;
  logic [PW-1:0]   head_next, cmt_next, tail_next;
  logic [PW-1:0]   occupancy, head_plus1;
  logic            alloc_ok, commit_ok, drain_ack, load_head, load_next;
  sb_state_t       state, state_next;
  bus32_t          aligned_data;
  logic [3:0]      aligned_be;

  store_align u_align (
    .byte_off  (alloc_addr_i[1:0]),
    .data      (alloc_data_i),
    .func3     (alloc_func3_i),
    .lane_data (aligned_data),
    .lane_be   (aligned_be)
  );

  assign occupancy   = tail_ptr - head_ptr;
  assign full_o      = (occupancy == PW'(SIZE));
  assign empty_o     = (tail_ptr == head_ptr);
  assign alloc_idx_o = tail_ptr[IW-1:0];
  assign head_plus1  = head_ptr + PW'(1);

  assign alloc_ok  = alloc_valid_i && !full_o;
  assign commit_ok = commit_valid_i && (commit_idx_i == cmt_ptr[IW-1:0]) && (cmt_ptr != tail_ptr);
  assign drain_ack = (state == SB_REQ) && dmem_ack_i;
  assign load_head = (state == SB_IDLE) && (head_ptr != cmt_ptr);
  assign load_next = drain_ack && (head_plus1 != cmt_ptr);

  // A commit that names anything but the oldest uncommitted entry is a ROB bug.
  commit_in_order: assert property (@(posedge clk_i) disable iff (!rstn_i)
    commit_valid_i |-> (commit_idx_i == cmt_ptr[IW-1:0]) && (cmt_ptr != tail_ptr));

  // Each pointer advances on its own event; a flush pulls tail back to the
  // commit point after counting any same-cycle commit.
  always_comb begin
    cmt_next  = cmt_ptr + PW'(commit_ok);
    head_next = head_ptr + PW'(drain_ack);
    tail_next = flush_i ? cmt_next : tail_ptr + PW'(alloc_ok);
  end

  // Pointer registers; reset empties the buffer, committed entries included.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_ptr <= '0;
      cmt_ptr  <= '0;
      tail_ptr <= '0;
    end else begin
      head_ptr <= head_next;
      cmt_ptr  <= cmt_next;
      tail_ptr <= tail_next;
    end
  end

  // Entry storage; contents only matter between head and tail, so no reset.
  always_ff @(posedge clk_i) begin
    if (alloc_ok) begin
      entries[tail_ptr[IW-1:0]] <= '{addr: {alloc_addr_i[31:2], 2'b00},
                                     data: aligned_data,
                                     be:   aligned_be};
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= SB_IDLE;
    else         state <= state_next;
  end

  // Drain FSM next state: stay in REQ while committed entries remain.
  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE: if (load_head) state_next = SB_REQ;
      SB_REQ:  if (drain_ack) state_next = load_next ? SB_REQ : SB_IDLE;
      default: state_next = SB_IDLE;
    endcase
  end

  // Drain FSM outputs.
  always_comb begin
    dmem_req_o = (state == SB_REQ);
  end

  // Request payload registers, held stable for the whole REQ phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dmem_addr_o <= '0;
      dmem_data_o <= '0;
      dmem_be_o   <= '0;
    end else if (load_head) begin
      dmem_addr_o <= entries[head_ptr[IW-1:0]].addr;
      dmem_data_o <= entries[head_ptr[IW-1:0]].data;
      dmem_be_o   <= entries[head_ptr[IW-1:0]].be;
    end else if (load_next) begin
      dmem_addr_o <= entries[head_plus1[IW-1:0]].addr;
      dmem_data_o <= entries[head_plus1[IW-1:0]].data;
      dmem_be_o   <= entries[head_plus1[IW-1:0]].be;
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] fwd_slot;
  logic [1:0]    unused_fwd_offset;

  assign unused_fwd_offset = fwd_addr_i[1:0];

  // Scan oldest to youngest so the youngest word match decides the result;
  // only a full-word store can supply the whole load value.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_slot   = '0;
    for (int i = 0; i < SIZE; i++) begin
      fwd_slot = head_ptr + PW'(i);
      if ((PW'(i) < occupancy) &&
          (entries[fwd_slot[IW-1:0]].addr[31:2] == fwd_addr_i[31:2])) begin
        fwd_hit_o  = (entries[fwd_slot[IW-1:0]].be == 4'b1111);
        fwd_data_o = fwd_hit_o ? entries[fwd_slot[IW-1:0]].data : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alloc_valid;
  logic [31:0] alloc_addr;
  logic [31:0] alloc_data;
  logic [2:0]  alloc_func3;
  logic [1:0]  alloc_idx;
  logic        full;
  logic        empty;
  logic        commit_valid;
  logic [1:0]  commit_idx;
  logic        flush;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
`ifdef STORE_FWD_EN
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  store_buffer dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .alloc_valid_i  (alloc_valid),
    .alloc_addr_i   (alloc_addr),
    .alloc_data_i   (alloc_data),
    .alloc_func3_i  (alloc_func3),
    .alloc_idx_o    (alloc_idx),
    .full_o         (full),
    .empty_o        (empty),
    .commit_valid_i (commit_valid),
    .commit_idx_i   (commit_idx),
    .flush_i        (flush),
`ifdef STORE_FWD_EN
    .fwd_addr_i     (fwd_addr),
    .fwd_hit_o      (fwd_hit),
    .fwd_data_o     (fwd_data),
`endif
    .dmem_req_o     (dmem_req),
    .dmem_addr_o    (dmem_addr),
    .dmem_data_o    (dmem_data),
    .dmem_be_o      (dmem_be),
    .dmem_ack_i     (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    alloc_valid  = 1'b0;
    alloc_addr   = '0;
    alloc_data   = '0;
    alloc_func3  = 3'b010;
    commit_valid = 1'b0;
    commit_idx   = '0;
    flush        = 1'b0;
    dmem_ack     = 1'b0;
`ifdef STORE_FWD_EN
    fwd_addr     = '0;
`endif
  endtask

  task automatic do_reset;
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    alloc_valid = 1'b1;
    alloc_addr  = a;
    alloc_data  = d;
    alloc_func3 = f;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic commit(input logic [1:0] idx);
    commit_valid = 1'b1;
    commit_idx   = idx;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (dmem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rstn = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    n_cmp++; if (dmem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00000000", dmem_addr); end
    n_cmp++; if (dmem_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 00000000", dmem_data); end
    n_cmp++; if (dmem_be !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_be: got %b expected 0000", dmem_be); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_cmp++; if (alloc_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_idx: got %0d expected 0", alloc_idx); end
`ifdef STORE_FWD_EN
    n_cmp++; if (fwd_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fwd_hit: got %b expected 0", fwd_hit); end
`endif
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_sw_drain;
    bit seen;
    do_reset();
    alloc(32'h100, 32'hDEADBEEF, 3'b010);
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_empty_after_alloc: got %b expected 0", empty); end
    n_cmp++; if (alloc_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL sw_next_idx: got %0d expected 1", alloc_idx); end
    commit(2'd0);
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_req_timeout: got %b expected 1", seen); end
    n_cmp++; if (dmem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL sw_addr: got %h expected 00000100", dmem_addr); end
    n_cmp++; if (dmem_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_data: got %h expected deadbeef", dmem_data); end
    n_cmp++; if (dmem_be !== 4'b1111) begin n_fail++; $display("[TB] FAIL sw_be: got %b expected 1111", dmem_be); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_req_after_ack: got %b expected 0", dmem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_empty_after_ack: got %b expected 1", empty); end
  endtask

  task automatic test_byte_store;
    bit seen;
    do_reset();
    alloc(32'h203, 32'h000000AB, 3'b000);
    commit(2'd0);
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_req_timeout: got %b expected 1", seen); end
    n_cmp++; if (dmem_addr !== 32'h200) begin n_fail++; $display("[TB] FAIL sb_addr: got %h expected 00000200", dmem_addr); end
    n_cmp++; if (dmem_data !== 32'hABABABAB) begin n_fail++; $display("[TB] FAIL sb_data: got %h expected abababab", dmem_data); end
    n_cmp++; if (dmem_be !== 4'b1000) begin n_fail++; $display("[TB] FAIL sb_be: got %b expected 1000", dmem_be); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    alloc(32'h302, 32'h0000CAFE, 3'b001);
    commit(2'd1);
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL sh_req_timeout: got %b expected 1", seen); end
    n_cmp++; if (dmem_data !== 32'hCAFECAFE) begin n_fail++; $display("[TB] FAIL sh_data: got %h expected cafecafe", dmem_data); end
    n_cmp++; if (dmem_be !== 4'b1100) begin n_fail++; $display("[TB] FAIL sh_be: got %b expected 1100", dmem_be); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit seen;
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_after_4: got %b expected 1", full); end
    n_cmp++; if (alloc_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL full_idx: got %0d expected 0", alloc_idx); end
    alloc(32'h310, 32'hFF, 3'b010);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_after_5th: got %b expected 1", full); end
    n_cmp++; if (alloc_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL full_idx_after_5th: got %0d expected 0", alloc_idx); end
    for (int i = 0; i < 4; i++) commit(2'(i));
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_req_timeout: got %b expected 1", seen); end
    dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_req_%0d: got %b expected 1", i, dmem_req); end
      n_cmp++; if (dmem_addr !== 32'h300 + 32'(4 * i)) begin n_fail++; $display("[TB] FAIL b2b_addr_%0d: got %h expected %h", i, dmem_addr, 32'h300 + 32'(4 * i)); end
      n_cmp++; if (dmem_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, dmem_data, 32'hA0 + 32'(i)); end
      tick();
    end
    dmem_ack = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_req_done: got %b expected 0", dmem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_full: got %b expected 0", full); end
    n_cmp++; if (alloc_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL b2b_wrap_idx: got %0d expected 0", alloc_idx); end
  endtask

  task automatic test_flush;
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h500 + 32'(4 * i), 32'h50 + 32'(i), 3'b010);
    commit(2'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (alloc_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL flush_idx: got %0d expected 1", alloc_idx); end
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_req_timeout: got %b expected 1", seen); end
    n_cmp++; if (dmem_addr !== 32'h500) begin n_fail++; $display("[TB] FAIL flush_addr: got %h expected 00000500", dmem_addr); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_more_req: got %b expected 0", dmem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
    n_cmp++; if (alloc_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL flush_idx_after: got %0d expected 1", alloc_idx); end
  endtask

  task automatic test_stall_reset;
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h600 + 32'(4 * i), 32'h60000000 + 32'(i), 3'b010);
    commit(2'd0);
    wait_req(seen);
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_req_timeout: got %b expected 1", seen); end
    for (int c = 0; c < 5; c++) begin
      commit_valid = (c < 2);
      commit_idx   = 2'(c + 1);
      n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_req_%0d: got %b expected 1", c, dmem_req); end
      n_cmp++; if (dmem_addr !== 32'h600) begin n_fail++; $display("[TB] FAIL stall_addr_%0d: got %h expected 00000600", c, dmem_addr); end
      n_cmp++; if (dmem_data !== 32'h60000000) begin n_fail++; $display("[TB] FAIL stall_data_%0d: got %h expected 60000000", c, dmem_data); end
      tick();
    end
    commit_valid = 1'b0;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_next_req: got %b expected 1", dmem_req); end
    n_cmp++; if (dmem_addr !== 32'h604) begin n_fail++; $display("[TB] FAIL stall_next_addr: got %h expected 00000604", dmem_addr); end
    n_cmp++; if (dmem_data !== 32'h60000001) begin n_fail++; $display("[TB] FAIL stall_next_data: got %h expected 60000001", dmem_data); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreq_reset_req: got %b expected 0", dmem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL midreq_reset_empty: got %b expected 1", empty); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_req: got %b expected 0", dmem_req); end
    n_cmp++; if (alloc_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL post_reset_idx: got %0d expected 0", alloc_idx); end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_forwarding;
    do_reset();
    alloc(32'h40, 32'h11111111, 3'b010);
    alloc(32'h40, 32'h22222222, 3'b010);
    fwd_addr = 32'h40;
    #1;
    n_cmp++; if (fwd_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_hit_sw: got %b expected 1", fwd_hit); end
    n_cmp++; if (fwd_data !== 32'h22222222) begin n_fail++; $display("[TB] FAIL fwd_data_sw: got %h expected 22222222", fwd_data); end
    alloc(32'h44, 32'h55, 3'b000);
    fwd_addr = 32'h44;
    #1;
    n_cmp++; if (fwd_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_hit_partial: got %b expected 0", fwd_hit); end
    fwd_addr = 32'h48;
    #1;
    n_cmp++; if (fwd_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_hit_miss: got %b expected 0", fwd_hit); end
    fwd_addr = 32'h42;
    #1;
    n_cmp++; if (fwd_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_hit_same_word: got %b expected 1", fwd_hit); end
    fwd_addr = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    test_reset();
    test_sw_drain();
    test_byte_store();
    test_back_to_back();
    test_flush();
    test_stall_reset();
`ifdef STORE_FWD_EN
    test_forwarding();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

In-order 4-entry store buffer between the memory stage and data memory. The memory stage allocates an entry for every store and carries the returned `store_buffer_idx_t` through writeback into the ROB. The ROB marks that entry committed when the store retires. Committed entries drain to data memory over a req/ack handshake, and a pipeline flush discards every uncommitted entry.

## Interface
Parameters:
- `SIZE`, default `STORE_BUFFER_SIZE` (4): number of entries; must be a power of two.

Ports:
- `clk_i`, in, 1: clock.
- `rstn_i`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `alloc_valid_i`, in, 1: memory stage presents a store.
- `alloc_addr_i`, in, 32 (`bus32_t`): byte address.
- `alloc_data_i`, in, 32: rs2 data, unshifted.
- `alloc_func3_i`, in, 3: 000 = SB, 001 = SH, 010 = SW.
- `alloc_idx_o`, out, `store_buffer_idx_t`: index given to the store this cycle (the tail).
- `full_o`, out, 1: no free entry.
- `empty_o`, out, 1: no valid entry.
- `commit_valid_i`, in, 1: ROB retires a store.
- `commit_idx_i`, in, `store_buffer_idx_t`: index being retired.
- `flush_i`, in, 1: exception or mispredict; discard uncommitted entries.
- `dmem_req_o`, out, 1: write request.
- `dmem_addr_o`, out, 32: word-aligned address, `{addr[31:2], 2'b00}`.
- `dmem_data_o`, out, 32: data shifted to byte lanes.
- `dmem_be_o`, out, 4: byte enables.
- `dmem_ack_i`, in, 1: write accepted.
- `fwd_addr_i`, in, 32: load address (present only with `STORE_FWD_EN`).
- `fwd_hit_o`, out, 1: forwarding result (present only with `STORE_FWD_EN`).
- `fwd_data_o`, out, 32: forwarded data (present only with `STORE_FWD_EN`).

## Operation
- State is held in three circular pointers, `head`, `cmt`, `tail`, each `$clog2(SIZE)+1` bits; the extra MSB disambiguates full from empty.
- Occupancy and pointer relations:
  - `full_o` = (`tail - head == SIZE`).
  - `empty_o` = (`tail == head`).
  - Invariant: `head <= cmt <= tail`.
- Allocation:
  - A store is written when `alloc_valid_i && !full_o`; then `tail++`.
  - If `full_o` is high, `alloc_valid_i` is ignored, even if an entry frees in the same cycle. Upstream must stall on `full_o`.
- Byte lanes and enables:
  - SB: `be = 4'b0001 << addr[1:0]`, data = `{4{data[7:0]}}`.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, data = `{2{data[15:0]}}`.
  - SW: `be = 4'b1111`.
  - Misaligned stores never arrive; the memory stage raises the exception for them.
- Commit:
  - On `commit_valid_i`, `commit_idx_i` must equal `cmt[idx]`; then `cmt++`.
  - A mismatch is a protocol error, trapped by an assertion, and the buffer state is unchanged.
- Flush: `tail <= cmt` (after applying a same-cycle commit). Committed entries are kept and still drain.
- Drain FSM:
  - IDLE: go to REQ when `head != cmt`, latching entry `head` into the dmem output registers.
  - REQ: `dmem_req_o = 1`; addr, data and be are held stable until `dmem_ack_i`.
  - On ack: `head++`. Go back to REQ with the next entry if `head+1 != cmt`, otherwise go to IDLE.
- Simultaneous events: alloc, commit, ack and flush may all occur in one cycle, and each pointer updates independently as above.

## Timing
- Reset values: all pointers 0, FSM IDLE, `dmem_req_o = 0`, `dmem_addr_o`/`dmem_data_o`/`dmem_be_o = 0`, `full_o = 0`, `empty_o = 1`, `alloc_idx_o = 0`, `fwd_hit_o = 0`.
- Reset mid-drain drops the request immediately and discards all entries, committed ones included.
- An allocated entry is visible in state at the next edge. `alloc_idx_o` is combinational from `tail`.
- Commit at edge N gives `dmem_req_o` high from cycle N+1. Minimum retire-to-request latency is 1 cycle.
- An ack in the first cycle of REQ is legal. Back-to-back committed entries sustain 1 store per cycle.
- `full_o` and `empty_o` are combinational from registered pointers.

## Configuration
- `STORE_FWD_EN` defined:
  - Adds a combinational search of valid entries, youngest first.
  - `fwd_hit_o = 1` when the youngest entry whose word address matches `fwd_addr_i[31:2]` is an SW; `fwd_data_o` is then that entry's data.
  - A partial-width match gives `fwd_hit_o = 0`, and the load must wait for `empty_o`.
- `STORE_FWD_EN` undefined: the fwd ports are absent and loads wait for `empty_o`.

## Structure
- Existing package items: `STORE_BUFFER_SIZE`, `store_buffer_idx_t`.
- New package items: `sb_entry_t` packed struct (`addr`, `data`, `be`) and `sb_state_t` enum (`SB_IDLE`, `SB_REQ`).
- Byte-lane formatting lives in one combinational sub-module, `store_align`, which is reused later by the load path.

## Test plan
- Reset, then alloc SW to 0x100 with data 0xDEADBEEF, commit idx 0 -> next cycle `dmem_req_o = 1`, addr 0x100, data 0xDEADBEEF, be 1111; ack -> `empty_o = 1`.
- Alloc SB to 0x203 with data 0x000000AB -> on drain, be 1000, data 0xABABABAB, addr 0x200.
- Alloc 4 stores without commit -> `full_o = 1`; a 5th alloc is ignored and `alloc_idx_o` stays 0. Commit all and ack all -> 4 writes in order, wrap-around, next `alloc_idx_o = 0`.
- Alloc 3, commit 1, flush -> only entry 0 drains, `tail = cmt = 1`, next `alloc_idx_o = 1`.
- Hold `dmem_ack_i` low for 5 cycles while committing more entries -> req, addr and data stable, no loss. Assert `rstn_i` low mid-REQ -> `dmem_req_o = 0` immediately and `empty_o = 1`.
- With `STORE_FWD_EN`: SW 0x11111111 then SW 0x22222222, both to 0x40, and lookup 0x40 -> `fwd_hit_o = 1`, data 0x22222222. SB to 0x44, lookup 0x44 -> `fwd_hit_o = 0`.
